scbd_slot_fill: RTL and testbench

- Receiving end of the wavepool-to-scoreboard feed interface: one instruction slot per wavefront (40 slots).
- On each feed grant it pops the wavefront's instruction queue and assembles 32- or 64-bit instructions into that slot.
- Reports slot occupancy to issue, and returns the "hungry" feedback signals the feeder consumes: issue_vacant, ins_half_reqd/ins_half_wfid.

---
 rtl/scbd_slot_fill_pkg.sv | 26 ++
 rtl/scbd_slot_entry.sv | 50 +++++
 rtl/scbd_slot_fill.sv | 102 ++++++++++
 tb/tb_scbd_slot_fill.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/scbd_slot_fill_pkg.sv
// scbd_slot_fill_pkg: shared constants, slot state encoding and instruction length decode
// for the scoreboard slot-fill block.
package scbd_slot_fill_pkg;
   localparam int NUM_WF   = 40;
   localparam int WFID_W   = 6;
   localparam int Q_DATA_W = 32;

   typedef enum logic [2:0] {
      S_EMPTY,
      S_WAIT_LO,
      S_HALF,
      S_WAIT_HI,
      S_FULL
   } slot_state_e;

   localparam logic [5:0] OP_VOP3  = 6'b110100;
   localparam logic [5:0] OP_DS    = 6'b110110;
   localparam logic [5:0] OP_MUBUF = 6'b111000;
   localparam logic [5:0] OP_MTBUF = 6'b111010;
   localparam logic [5:0] OP_MIMG  = 6'b111100;
   localparam logic [5:0] OP_EXP   = 6'b111110;

   function automatic logic is_64b_encoding(input logic [Q_DATA_W-1:0] dw);
      return dw[31:26] inside {OP_VOP3, OP_DS, OP_MUBUF, OP_MTBUF, OP_MIMG, OP_EXP};
   endfunction
endpackage

// File: rtl/scbd_slot_entry.sv
// scbd_slot_entry: one wavefront's instruction slot; assembles a 32/64-bit instruction
// from one or two queue returns and frees on issue.
module scbd_slot_entry
   import scbd_slot_fill_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                feed,
   input  logic                ret,
   input  logic [Q_DATA_W-1:0] ret_data,
   input  logic                issue,
   input  logic                flush,
   output slot_state_e         state,
   output logic [63:0]         instr,
   output logic                half,
   output logic                vacate
);
   slot_state_e nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_EMPTY;
      else      state <= nxt;
   end

   always_comb begin
      nxt = state;
      if (flush) nxt = S_EMPTY;
      else begin
         case (state)
            S_EMPTY:   nxt = feed ? S_WAIT_LO : S_EMPTY;
            S_WAIT_LO: nxt = !ret ? S_WAIT_LO : is_64b_encoding(ret_data) ? S_HALF : S_FULL;
            S_HALF:    nxt = feed ? S_WAIT_HI : S_HALF;
            S_WAIT_HI: nxt = ret ? S_FULL : S_WAIT_HI;
            S_FULL:    nxt = issue ? S_EMPTY : S_FULL;
            default:   nxt = S_EMPTY;
         endcase
      end
   end

   // low dword write clears the high half so 32-bit instructions read back zero-extended
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                              instr <= '0;
      else if (flush)                        instr <= '0;
      else if (ret && state == S_WAIT_LO)    instr <= {32'b0, ret_data};
      else if (ret && state == S_WAIT_HI)    instr[63:32] <= ret_data;
   end

   assign half   = !flush && ret && state == S_WAIT_LO && is_64b_encoding(ret_data);
   assign vacate = !flush && issue && state == S_FULL;
endmodule

// File: rtl/scbd_slot_fill.sv
// scbd_slot_fill: wavepool-to-scoreboard feed receiver, one instruction slot per wavefront.
// Optional SCBD_SLOT_PROTO_CHECK_EN adds a sticky proto_err output and matching assertions.
module scbd_slot_fill
   import scbd_slot_fill_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                feed_valid,
   input  logic [WFID_W-1:0]   feed_wfid,
   output logic                q_rd_en,
   output logic [WFID_W-1:0]   q_rd_wfid,
   input  logic [Q_DATA_W-1:0] q_rd_data,
   input  logic                issue_valid,
   input  logic [WFID_W-1:0]   issue_wfid,
   output logic [63:0]         issue_instr,
   output logic [NUM_WF-1:0]   slot_ready,
   output logic [NUM_WF-1:0]   issue_vacant,
   output logic                ins_half_reqd,
   output logic [WFID_W-1:0]   ins_half_wfid,
   input  logic                flush_valid,
   input  logic [WFID_W-1:0]   flush_wfid
`ifdef SCBD_SLOT_PROTO_CHECK_EN
   ,
   output logic                proto_err
`endif
);
   logic              pend_valid;
   logic [WFID_W-1:0] pend_wfid;
   logic              ret_ok;
   slot_state_e       st [NUM_WF];
   logic [63:0]       instr [NUM_WF];
   logic [NUM_WF-1:0] half_v;
   logic [NUM_WF-1:0] vac_v;

   assign q_rd_en   = feed_valid && !(flush_valid && flush_wfid == feed_wfid);
   assign q_rd_wfid = feed_wfid;
   // a flush landing on the returning wavefront drops the data in flight
   assign ret_ok    = pend_valid && !(flush_valid && flush_wfid == pend_wfid);

`ifdef SCBD_SLOT_PROTO_CHECK_EN
   logic [NUM_WF-1:0] feed_err_v;
   logic [NUM_WF-1:0] issue_err_v;
   logic              pend_err;
`endif

   for (genvar i = 0; i < NUM_WF; i++) begin : g_slot
      localparam logic [WFID_W-1:0] id = WFID_W'(i);
      scbd_slot_entry u_entry (
         .clk      (clk),
         .rst      (rst),
         .feed     (q_rd_en && feed_wfid == id),
         .ret      (ret_ok && pend_wfid == id),
         .ret_data (q_rd_data),
         .issue    (issue_valid && issue_wfid == id),
         .flush    (flush_valid && flush_wfid == id),
         .state    (st[i]),
         .instr    (instr[i]),
         .half     (half_v[i]),
         .vacate   (vac_v[i])
      );
      assign slot_ready[i] = st[i] == S_FULL;
`ifdef SCBD_SLOT_PROTO_CHECK_EN
      assign feed_err_v[i]  = feed_valid && feed_wfid == id && !(st[i] == S_EMPTY || st[i] == S_HALF);
      assign issue_err_v[i] = issue_valid && issue_wfid == id && st[i] != S_FULL;
`endif
   end

   always_comb begin
      issue_instr = '0;
      for (int i = 0; i < NUM_WF; i++)
         if (issue_wfid == WFID_W'(i)) issue_instr = instr[i];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_valid    <= 1'b0;
         pend_wfid     <= '0;
         issue_vacant  <= '0;
         ins_half_reqd <= 1'b0;
         ins_half_wfid <= '0;
      end else begin
         pend_valid    <= q_rd_en;
         pend_wfid     <= feed_wfid;
         issue_vacant  <= vac_v;
         ins_half_reqd <= |half_v;
         if (|half_v) ins_half_wfid <= pend_wfid;
      end
   end

`ifdef SCBD_SLOT_PROTO_CHECK_EN
   assign pend_err = q_rd_en && pend_valid && feed_wfid == pend_wfid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                        proto_err <= 1'b0;
      else if (|feed_err_v || |issue_err_v || pend_err) proto_err <= 1'b1;
   end

   a_feed_state:  assert property (@(posedge clk) disable iff (!rst) !(|feed_err_v));
   a_issue_state: assert property (@(posedge clk) disable iff (!rst) !(|issue_err_v));
   a_pend_wfid:   assert property (@(posedge clk) disable iff (!rst) !pend_err);
`endif
endmodule

// File: tb/tb_scbd_slot_fill.sv
// tb_scbd_slot_fill: directed stimulus with queued expectations for slot_ready changes,
// issue_vacant pulses and ins_half_reqd pulses, checked by an independent monitor.
module tb_scbd_slot_fill;
   import scbd_slot_fill_pkg::*;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                feed_valid = 1'b0;
   logic [WFID_W-1:0]   feed_wfid = '0;
   logic                q_rd_en;
   logic [WFID_W-1:0]   q_rd_wfid;
   logic [Q_DATA_W-1:0] q_rd_data = '0;
   logic                issue_valid = 1'b0;
   logic [WFID_W-1:0]   issue_wfid = '0;
   logic [63:0]         issue_instr;
   logic [NUM_WF-1:0]   slot_ready;
   logic [NUM_WF-1:0]   issue_vacant;
   logic                ins_half_reqd;
   logic [WFID_W-1:0]   ins_half_wfid;
   logic                flush_valid = 1'b0;
   logic [WFID_W-1:0]   flush_wfid = '0;
`ifdef SCBD_SLOT_PROTO_CHECK_EN
   logic                proto_err;
`endif

   scbd_slot_fill dut (
      .clk           (clk),
      .rst           (rst),
      .feed_valid    (feed_valid),
      .feed_wfid     (feed_wfid),
      .q_rd_en       (q_rd_en),
      .q_rd_wfid     (q_rd_wfid),
      .q_rd_data     (q_rd_data),
      .issue_valid   (issue_valid),
      .issue_wfid    (issue_wfid),
      .issue_instr   (issue_instr),
      .slot_ready    (slot_ready),
      .issue_vacant  (issue_vacant),
      .ins_half_reqd (ins_half_reqd),
      .ins_half_wfid (ins_half_wfid),
      .flush_valid   (flush_valid),
      .flush_wfid    (flush_wfid)
`ifdef SCBD_SLOT_PROTO_CHECK_EN
      ,
      .proto_err     (proto_err)
`endif
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   logic [NUM_WF-1:0] rdy_q [$];
   logic [NUM_WF-1:0] vac_q [$];
   logic [WFID_W-1:0] half_q [$];
   logic [NUM_WF-1:0] prev_rdy = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name, input logic [63:0] act);
      n_chk++;
      n_fail++;
      $display("FAIL %s: got %h with no expected event queued", name, act);
   endtask

   always @(negedge clk) begin
      if (ins_half_reqd) begin
         if (half_q.size() == 0) unexpected("half_extra", 64'(ins_half_wfid));
         else check("half_wfid", 64'(ins_half_wfid), 64'(half_q.pop_front()));
      end
      if (issue_vacant != '0) begin
         if (vac_q.size() == 0) unexpected("vacant_extra", 64'(issue_vacant));
         else check("issue_vacant", 64'(issue_vacant), 64'(vac_q.pop_front()));
      end
      if (slot_ready != prev_rdy) begin
         if (rdy_q.size() == 0) unexpected("ready_extra", 64'(slot_ready));
         else check("slot_ready", 64'(slot_ready), 64'(rdy_q.pop_front()));
         prev_rdy = slot_ready;
      end
   end

   task automatic cyc(input logic fv, input logic [5:0] fid, input logic [31:0] d,
                      input logic iv = 1'b0, input logic [5:0] iid = '0,
                      input logic flv = 1'b0, input logic [5:0] flid = '0);
      @(posedge clk);
      #1;
      feed_valid  = fv;
      feed_wfid   = fid;
      q_rd_data   = d;
      issue_valid = iv;
      issue_wfid  = iid;
      flush_valid = flv;
      flush_wfid  = flid;
   endtask

   initial begin
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      #1;
      check("rst_ready", 64'(slot_ready), 64'h0);
      check("rst_vacant", 64'(issue_vacant), 64'h0);
      check("rst_half", 64'(ins_half_reqd), 64'h0);
      check("rst_half_wfid", 64'(ins_half_wfid), 64'h0);
      rst = 1'b1;
      cyc(0, 0, 0);

      // 32-bit VOP1 into wf3
      rdy_q.push_back(40'h8);
      cyc(1, 3, 0);
      #1;
      check("feed3_rd_en", 64'(q_rd_en), 64'h1);
      check("feed3_rd_wfid", 64'(q_rd_wfid), 64'h3);
      cyc(0, 0, 32'h7E000000);
      cyc(0, 0, 0, 0, 3);
      #1;
      check("instr_wf3", issue_instr, 64'h0000_0000_7E00_0000);

      // 64-bit VOP3 into wf5, refed after the half request
      half_q.push_back(6'd5);
      rdy_q.push_back(40'h28);
      cyc(1, 5, 0);
      cyc(0, 0, 32'hD2000001);
      cyc(1, 5, 0);
      cyc(0, 0, 32'h00020304);
      cyc(0, 0, 0, 0, 5);
      #1;
      check("instr_wf5", issue_instr, 64'h0002_0304_D200_0001);

      // opcode 110101 is just outside VOP3: must stay 32-bit; then issue wf7
      rdy_q.push_back(40'hA8);
      rdy_q.push_back(40'h28);
      vac_q.push_back(40'h80);
      cyc(1, 7, 0);
      cyc(0, 0, 32'hD4000000);
      cyc(0, 0, 0, 1, 7);
      #1;
      check("instr_wf7", issue_instr, 64'h0000_0000_D400_0000);
      cyc(0, 0, 0);
      cyc(0, 0, 0);

      // flush wf9 while its 64-bit low dword returns; slot must come back EMPTY
      rdy_q.push_back(40'h228);
      rdy_q.push_back(40'h28);
      vac_q.push_back(40'h200);
      cyc(1, 9, 0);
      cyc(0, 0, 32'hD2000001, 0, 0, 1, 9);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      cyc(1, 9, 0);
      cyc(0, 0, 32'h12345678);
      cyc(0, 0, 0, 0, 9);
      #1;
      check("instr_wf9_refill", issue_instr, 64'h0000_0000_1234_5678);
      cyc(0, 0, 0, 1, 9);
      cyc(0, 0, 0);
      cyc(0, 0, 0);

      // feed and flush wf2 together: no pop, nothing lands
      cyc(1, 2, 0, 0, 0, 1, 2);
      #1;
      check("flush_feed_rd_en", 64'(q_rd_en), 64'h0);
      cyc(0, 0, 32'h7E000000);
      cyc(0, 0, 0);
      cyc(0, 0, 0);

      // issue wf5 and feed wf4 in the same cycle; wf4 gets an EXP (64-bit)
      vac_q.push_back(40'h20);
      rdy_q.push_back(40'h08);
      half_q.push_back(6'd4);
      rdy_q.push_back(40'h18);
      cyc(1, 4, 0, 1, 5);
      cyc(0, 0, 32'hF8000000);
      cyc(1, 4, 0);
      cyc(0, 0, 32'h11112222);
      cyc(0, 0, 0, 0, 4);
      #1;
      check("instr_wf4", issue_instr, 64'h1111_2222_F800_0000);

      // issue to an EMPTY slot is ignored
      cyc(0, 0, 0, 1, 1);
      cyc(0, 0, 0);
      #1;
      check("ready_after_bad_issue", 64'(slot_ready), 64'h18);
`ifdef SCBD_SLOT_PROTO_CHECK_EN
      check("proto_err_set", 64'(proto_err), 64'h1);
`endif
      cyc(0, 0, 0);

      // reset while wf6 data is in flight
      rdy_q.push_back(40'h0);
      cyc(1, 6, 0);
      cyc(0, 0, 32'h7E000000);
      rst = 1'b0;
      cyc(0, 0, 0);
      #1;
      check("ready_in_reset", 64'(slot_ready), 64'h0);
`ifdef SCBD_SLOT_PROTO_CHECK_EN
      check("proto_err_cleared", 64'(proto_err), 64'h0);
`endif
      rst = 1'b1;
      cyc(0, 0, 0);
      cyc(0, 0, 0, 0, 3);
      #1;
      check("ready_after_reset", 64'(slot_ready), 64'h0);
      check("instr_wf3_cleared", issue_instr, 64'h0);
      cyc(0, 0, 0);

      check("ready_events_left", 64'(rdy_q.size()), 64'h0);
      check("vacant_events_left", 64'(vac_q.size()), 64'h0);
      check("half_events_left", 64'(half_q.size()), 64'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
